// File: rtl/psum_drain.sv
// Readout engine for one sblk_conv_unit partial-sum buffer.
// It issues a window of buffer reads, captures the returned words and streams each word out as two PSUM-wide elements.
module psum_drain #(
    parameter int PBUF_ADDR_LEN = 9,
    parameter int PSUM_DATA_LEN = 32,
    parameter int RD_LAT        = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                         clk_l,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [PBUF_ADDR_LEN-1:0]     base_addr,
    input  logic [PBUF_ADDR_LEN:0]       num_words,
    output logic                         busy,
    output logic                         done,
    output logic [PBUF_ADDR_LEN-1:0]     pbuf_rd_addr,
    input  logic [2*PSUM_DATA_LEN-1:0]   pbuf_rd_data,
    output logic [PSUM_DATA_LEN-1:0]     out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int WORD_W = 2 * PSUM_DATA_LEN;
    localparam int NW_W   = PBUF_ADDR_LEN + 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [NW_W-1:0]     num_words_q;
    logic [NW_W-1:0]     issue_cnt;
    logic [NW_W-1:0]     pop_cnt;
    logic [RD_LAT-1:0]   tag_pipe;
    logic [WORD_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic                half_sel;

    logic                accept;
    logic                issue;
    logic                last_issue;
    logic                credit_ok;
    logic [CRD_W-1:0]    inflight;
    logic                capture;
    logic                xfer;
    logic                pop;
    logic [WORD_W-1:0]   head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = (num_words == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (issue && last_issue) state_nxt = ST_FLUSH;
            ST_FLUSH: if (xfer && out_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != ST_IDLE);
        done   = (state == ST_DONE);
        accept = (state == ST_IDLE) && start;
        issue  = (state == ST_ISSUE) && credit_ok;
    end

    // The credit counts reads still in the pipe plus stored words, so a capture never meets a full FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CRD_W'(tag_pipe[i]);
        end
        credit_ok  = (inflight + CRD_W'(fifo_count)) < CRD_W'(FIFO_DEPTH);
        last_issue = (issue_cnt == num_words_q - NW_W'(1));
        capture    = tag_pipe[RD_LAT-1];
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            num_words_q  <= '0;
            issue_cnt    <= '0;
            pbuf_rd_addr <= '0;
        end else if (accept) begin
            num_words_q <= num_words;
            issue_cnt   <= '0;
            if (num_words != '0) begin
                pbuf_rd_addr <= base_addr;
            end
        end else if (issue) begin
            issue_cnt    <= issue_cnt + NW_W'(1);
            pbuf_rd_addr <= pbuf_rd_addr + PBUF_ADDR_LEN'(1);
        end
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // NOTE: FIFO storage is not reset; only pointers and count are, and out_data is gated by out_valid.
    always_ff @(posedge clk_l) begin
        if (capture) begin
            fifo_mem[wr_ptr] <= pbuf_rd_data;
        end
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Low half first: it holds the earlier sum in the write packing.
    always_comb begin
        head      = fifo_mem[rd_ptr];
        out_valid = (fifo_count != '0);
        out_data  = '0;
        if (out_valid) begin
            out_data = half_sel ? head[WORD_W-1:PSUM_DATA_LEN] : head[PSUM_DATA_LEN-1:0];
        end
        xfer     = out_valid && out_ready;
        pop      = xfer && half_sel;
        out_last = out_valid && half_sel && (pop_cnt == num_words_q - NW_W'(1));
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            half_sel <= 1'b0;
            pop_cnt  <= '0;
        end else if (accept) begin
            half_sel <= 1'b0;
            pop_cnt  <= '0;
        end else if (xfer) begin
            half_sel <= ~half_sel;
            if (half_sel) pop_cnt <= pop_cnt + NW_W'(1);
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: a latency-3 buffer model plus an element-queue reference built from
// the address window, under directed and randomized backpressure.
module tb_psum_drain;

    localparam int AW     = 9;
    localparam int NW     = AW + 1;
    localparam int DW     = 32;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 4;

    logic            clk_l = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [NW-1:0]   num_words = '0;
    logic            busy;
    logic            done;
    logic [AW-1:0]   pbuf_rd_addr;
    logic [2*DW-1:0] pbuf_rd_data = '0;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_last;

    logic [2*DW-1:0] mem [2**AW];
    logic [AW-1:0]   a1 = '0;
    logic [AW-1:0]   a2 = '0;
    int              tests = 0;
    int              fails = 0;

    always #5 clk_l = ~clk_l;

    psum_drain #(
        .PBUF_ADDR_LEN (AW),
        .PSUM_DATA_LEN (DW),
        .RD_LAT        (RD_LAT),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_l        (clk_l),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .pbuf_rd_addr (pbuf_rd_addr),
        .pbuf_rd_data (pbuf_rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    // Buffer model: address register, array cycle, output register.
    always @(posedge clk_l) begin
        a1           <= pbuf_rd_addr;
        a2           <= a1;
        pbuf_rd_data <= mem[a2];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2**AW; i++) mem[i] = {$urandom, $urandom};
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " busy"}, busy, 0);
        check({name, " done"}, done, 0);
        check({name, " valid"}, out_valid, 0);
        check({name, " last"}, out_last, 0);
        check({name, " data"}, out_data, 0);
        check({name, " addr"}, pbuf_rd_addr, 0);
    endtask

    // Runs one command starting right after a posedge (+#1); returns likewise.
    task automatic drain(input string name, input logic [AW-1:0] base, input int n,
                         input bit rand_ready, input int inj_cycle, input int rst_cycle);
        logic [DW-1:0] exp_q[$];
        logic [AW-1:0] addr_q[$];
        logic [AW-1:0] a;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] exp_elem;
        bit            prev_stall = 1'b0;
        bit            reset_hit = 1'b0;
        bit            exp_last;
        int            elems = 0;
        int            done_cyc = -1;
        int            last_hs = -1;
        int            first_valid = -1;

        for (int k = 0; k < n; k++) begin
            a = base + AW'(k);
            exp_q.push_back(mem[a][DW-1:0]);
            exp_q.push_back(mem[a][2*DW-1:DW]);
        end

        start     = 1'b1;
        base_addr = base;
        num_words = NW'(n);
        @(posedge clk_l); #1;

        for (int cyc = 1; cyc <= 400; cyc++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == inj_cycle) begin
                start     = 1'b1;
                base_addr = base + AW'(100);
                num_words = NW'(5);
            end else begin
                start = 1'b0;
            end
            if (cyc == rst_cycle) begin
                rst_n = 1'b0;
                #1;
                check_outputs_zero({name, " async reset"});
                reset_hit = 1'b1;
                break;
            end

            @(negedge clk_l);
            if (cyc == 1) begin
                check({name, " busy c1"}, busy, 1);
                if (n > 0) check({name, " first addr"}, pbuf_rd_addr, base);
            end
            if (busy && n > 0 && (addr_q.size() == 0 || addr_q[$] != pbuf_rd_addr))
                addr_q.push_back(pbuf_rd_addr);
            if (prev_stall) begin
                check({name, " stall valid"}, out_valid, 1);
                check({name, " stall data"}, out_data, prev_data);
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            check({name, " credit"}, (int'(dut.inflight) + int'(dut.fifo_count)) <= DEPTH, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({name, " extra element"}, elems + 1, 2 * n);
                end else begin
                    exp_last = (exp_q.size() == 1);
                    exp_elem = exp_q.pop_front();
                    check({name, " data"}, out_data, exp_elem);
                    check({name, " last"}, out_last, exp_last);
                end
                elems++;
                last_hs = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk_l); #1;
        end

        if (!reset_hit) begin
            if (n == 0) check({name, " done cycle"}, done_cyc, 1);
            else        check({name, " done cycle"}, done_cyc, last_hs + 1);
            check({name, " elements"}, elems, 2 * n);
            if (!rand_ready && n > 0) check({name, " first valid"}, first_valid, 2 + RD_LAT);
            for (int k = 0; k < n; k++) begin
                a = base + AW'(k);
                if (addr_q.size() > k) check({name, " addr seq"}, addr_q[k], a);
                else                   check({name, " addr count"}, addr_q.size(), k + 1);
            end
            @(posedge clk_l); #1;
            start = 1'b0;
            @(negedge clk_l);
            check({name, " busy after done"}, busy, 0);
            check({name, " done pulse"}, done, 0);
            @(posedge clk_l); #1;
        end
    endtask

    initial begin
        fill_random();
        for (int k = 0; k < 3; k++)
            mem[9'h010 + k] = {32'hB000_0000 | 32'(k), 32'hA000_0000 | 32'(k)};

        repeat (3) @(posedge clk_l);
        #1;
        check_outputs_zero("reset state");
        rst_n = 1'b1;
        @(posedge clk_l); #1;

        drain("basic", 9'h010, 3, 1'b0, -1, -1);

        fill_random();
        drain("backpressure", 9'($urandom), 8, 1'b1, -1, -1);
        drain("backpressure2", 9'($urandom), 8, 1'b1, -1, -1);

        drain("wrap", 9'h1FE, 4, 1'b0, -1, -1);
        drain("wrap bp", 9'h1FD, 5, 1'b1, -1, -1);

        drain("zero length", 9'h055, 0, 1'b0, 1, -1);
        drain("ignored start", 9'h040, 5, 1'b0, 3, -1);

        drain("reset mid", 9'h080, 16, 1'b0, -1, 6);
        repeat (2) @(posedge clk_l);
        #1;
        rst_n = 1'b1;
        @(posedge clk_l); #1;

        fill_random();
        drain("after reset", 9'h123, 6, 1'b1, -1, -1);
        drain("long bp", 9'h1F0, 40, 1'b1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
